// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port memory
// between the edge-detection accelerator (requester 0) and the host port (requester 1).
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int BCNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BURST);
  localparam logic [BCNT_W-1:0] ONE_CNT = BCNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic                busy_q, busy_d;
  logic                grant0, grant1;
  logic                burst_full;
  logic [BCNT_W-1:0]   bcnt_inc;

  // A burst limit of zero disables the fairness cutoff entirely.
  assign burst_full = (MAX_BURST != 0) && (bcnt_q >= MAX_CNT);
  assign bcnt_inc   = (bcnt_q == '1) ? bcnt_q : bcnt_q + ONE_CNT;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_q)) grant0 = 1'b1;
          else if (req1)                 grant1 = 1'b1;
        end
        OWN0: begin
          if (req0 && (!req1 || !burst_full)) grant0 = 1'b1;
          else if (req1)                      grant1 = 1'b1;
        end
        OWN1: begin
          if (req1 && (!req0 || !burst_full)) grant1 = 1'b1;
          else if (req0)                      grant0 = 1'b1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    if (grant0) begin
      if (state_q == OWN0) begin
        bcnt_d = bcnt_inc;
      end else begin
        state_d = OWN0;
        bcnt_d  = ONE_CNT;
        last_d  = 1'b0;
      end
    end else if (grant1) begin
      if (state_q == OWN1) begin
        bcnt_d = bcnt_inc;
      end else begin
        state_d = OWN1;
        bcnt_d  = ONE_CNT;
        last_d  = 1'b1;
      end
    end else begin
      state_d = IDLE;
      bcnt_d  = '0;
    end
    rvalid0_d = grant0 && !we0;
    rvalid1_d = grant1 && !we1;
    busy_d    = (state_d != IDLE);
  end

  always_comb begin
    mem_en    = grant0 || grant1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (grant1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      bcnt_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      busy_q    <= busy_d;
    end
  end

  // A read issued just before reset must not surface during the reset cycle.
  assign rvalid0 = rvalid0_q && !reset;
  assign rvalid1 = rvalid1_q && !reset;
  assign gnt0    = grant0;
  assign gnt1    = grant1;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, then randomized traffic against
// an owner/run-length reference model with a shadow memory.
module tb_mem_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {a ^ 16'hA5A5, a};
  endfunction

  // Memory attached to the arbiter: 1-cycle synchronous read.
  logic [31:0] sram [0:65535];
  initial for (int i = 0; i < 65536; i++) sram[i] = init_word(16'(i));
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  // Reference model: who owns the memory, how long the current run is,
  // who was served last, what read is due back, and a shadow of memory.
  int          m_owner = -1;
  int          m_run   = 0;
  int          m_last  = 1;
  bit          exp_rv [2];
  logic [31:0] exp_rd [2];
  logic [31:0] shadow [logic [15:0]];

  function automatic logic [31:0] shadow_rd(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic int exp_grant();
    bit r [2];
    int own, oth;
    r[0] = req0;
    r[1] = req1;
    if (reset) return -1;
    if (!r[0] && !r[1]) return -1;
    if (m_owner < 0) begin
      if (r[0] && r[1]) return 1 - m_last;
      return r[0] ? 0 : 1;
    end
    own = m_owner;
    oth = 1 - own;
    if (!r[own]) return oth;
    if (!r[oth]) return own;
    if (m_run < MB) return own;
    return oth;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(output int g);
    logic [15:0] ea;
    logic [31:0] ed;
    logic        ewe;
    g   = exp_grant();
    ea  = (g == 0) ? addr0 : (g == 1) ? addr1 : 16'h0;
    ed  = (g == 0) ? wdata0 : (g == 1) ? wdata1 : 32'h0;
    ewe = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
    check("gnt0", 32'(gnt0), 32'(g == 0));
    check("gnt1", 32'(gnt1), 32'(g == 1));
    check("mem_en", 32'(mem_en), 32'(g >= 0));
    check("mem_we", 32'(mem_we), 32'(ewe));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_wdata", mem_wdata, ed);
    check("rvalid0", 32'(rvalid0), 32'(exp_rv[0] && !reset));
    check("rvalid1", 32'(rvalid1), 32'(exp_rv[1] && !reset));
    if (exp_rv[0] && !reset) check("rdata0", rdata0, exp_rd[0]);
    if (exp_rv[1] && !reset) check("rdata1", rdata1, exp_rd[1]);
    check("busy", 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic model_clock(input int g);
    @(posedge clk);
    if (reset) begin
      m_owner   = -1;
      m_run     = 0;
      m_last    = 1;
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
    end else begin
      exp_rv[0] = (g == 0) && !we0;
      exp_rv[1] = (g == 1) && !we1;
      exp_rd[0] = shadow_rd(addr0);
      exp_rd[1] = shadow_rd(addr1);
      if (g == 0 && we0) shadow[addr0] = wdata0;
      if (g == 1 && we1) shadow[addr1] = wdata1;
      if (g < 0) begin
        m_owner = -1;
        m_run   = 0;
      end else if (g == m_owner) begin
        m_run++;
      end else begin
        m_owner = g;
        m_run   = 1;
        m_last  = g;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [1:0]  gnt;
    logic        mwe;
    logic [15:0] maddr;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        bsy;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic rst,
                              input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1,
                              input logic [1:0] gnt, input logic mwe, input logic [15:0] maddr,
                              input logic [1:0] rv, input logic [31:0] rd, input logic bsy);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.gnt = gnt; v.mwe = mwe; v.maddr = maddr; v.rv = rv; v.rd = rd; v.bsy = bsy;
    tbl.push_back(v);
  endfunction

  initial begin
    int g;

    // reset held with both requesting; requester 0 wins the first tie
    for (int i = 0; i < 3; i++)
      add(1, 1,0,16'h0001,0, 1,0,16'h0002,0, 2'b00,0,16'h0000, 2'b00,0, 0);
    add(0, 1,1,16'h0010,32'hDEADBEEF, 1,0,16'h0002,0, 2'b01,1,16'h0010, 2'b00,0, 0);
    // requester 0 alone reads back its write
    add(0, 1,0,16'h0010,0, 0,0,16'h0000,0, 2'b01,0,16'h0010, 2'b00,0, 1);
    add(0, 0,0,16'h0000,0, 0,0,16'h0000,0, 2'b00,0,16'h0000, 2'b01,32'hDEADBEEF, 1);
    // both streaming: bursts of four alternate with no bubble
    add(0, 1,0,16'h0100,0, 1,0,16'h0200,0, 2'b10,0,16'h0200, 2'b00,0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1,0,16'h0100,0, 1,0,16'h0200,0, 2'b10,0,16'h0200, 2'b10,init_word(16'h0200), 1);
    add(0, 1,0,16'h0100,0, 1,0,16'h0200,0, 2'b01,0,16'h0100, 2'b10,init_word(16'h0200), 1);
    for (int i = 0; i < 3; i++)
      add(0, 1,0,16'h0100,0, 1,0,16'h0200,0, 2'b01,0,16'h0100, 2'b01,init_word(16'h0100), 1);
    add(0, 1,0,16'h0100,0, 1,0,16'h0200,0, 2'b10,0,16'h0200, 2'b01,init_word(16'h0100), 1);
    add(0, 0,0,16'h0000,0, 0,0,16'h0000,0, 2'b00,0,16'h0000, 2'b10,init_word(16'h0200), 1);
    // requester 1 waits out a four-beat burst, gets one beat, hands back
    add(0, 1,1,16'h0300,32'h11111111, 0,0,16'h0000,0, 2'b01,1,16'h0300, 2'b00,0, 0);
    add(0, 1,1,16'h0301,32'h22222222, 0,0,16'h0000,0, 2'b01,1,16'h0301, 2'b00,0, 1);
    add(0, 1,1,16'h0302,32'h33333333, 1,0,16'h0400,0, 2'b01,1,16'h0302, 2'b00,0, 1);
    add(0, 1,1,16'h0302,32'h33333333, 1,0,16'h0400,0, 2'b01,1,16'h0302, 2'b00,0, 1);
    add(0, 1,1,16'h0302,32'h33333333, 1,0,16'h0400,0, 2'b10,0,16'h0400, 2'b00,0, 1);
    add(0, 1,1,16'h0302,32'h33333333, 0,0,16'h0400,0, 2'b01,1,16'h0302, 2'b10,init_word(16'h0400), 1);
    // reads straddling an ownership switch return in order to the issuer
    add(0, 1,1,16'h0303,32'h44444444, 1,0,16'h0000,0, 2'b01,1,16'h0303, 2'b00,0, 1);
    add(0, 1,1,16'h0303,32'h44444444, 1,0,16'h0000,0, 2'b01,1,16'h0303, 2'b00,0, 1);
    add(0, 1,0,16'h6300,0, 1,0,16'h0000,0, 2'b01,0,16'h6300, 2'b00,0, 1);
    add(0, 1,0,16'h6300,0, 1,0,16'h0000,0, 2'b10,0,16'h0000, 2'b01,init_word(16'h6300), 1);
    add(0, 0,0,16'h0000,0, 0,0,16'h0000,0, 2'b00,0,16'h0000, 2'b10,init_word(16'h0000), 1);
    // reset right after a granted read swallows its return
    add(0, 0,0,16'h0000,0, 1,0,16'h0005,0, 2'b10,0,16'h0005, 2'b00,0, 0);
    add(1, 0,0,16'h0000,0, 1,0,16'h0005,0, 2'b00,0,16'h0000, 2'b00,0, 1);
    add(0, 0,0,16'h0000,0, 0,0,16'h0000,0, 2'b00,0,16'h0000, 2'b00,0, 0);
    add(0, 1,0,16'h0007,0, 1,0,16'h0008,0, 2'b01,0,16'h0007, 2'b00,0, 0);
    add(0, 0,0,16'h0000,0, 0,0,16'h0000,0, 2'b00,0,16'h0000, 2'b01,init_word(16'h0007), 1);

    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    model_clock(-1);

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      #4;
      check($sformatf("tbl%0d_gnt", i), 32'({gnt1, gnt0}), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].gnt != 2'b00));
      check($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].mwe));
      check($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
      check($sformatf("tbl%0d_rv", i), 32'({rvalid1, rvalid0}), 32'(tbl[i].rv));
      if (tbl[i].rv[0]) check($sformatf("tbl%0d_rd0", i), rdata0, tbl[i].rd);
      if (tbl[i].rv[1]) check($sformatf("tbl%0d_rd1", i), rdata1, tbl[i].rd);
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      model_check(g);
      model_clock(g);
    end

    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 3) != 0);
      we0    = $urandom_range(0, 1) == 1;
      addr0  = 16'($urandom_range(0, 15));
      wdata0 = $urandom;
      req1   = ($urandom_range(0, 3) != 0);
      we1    = $urandom_range(0, 1) == 1;
      addr1  = 16'($urandom_range(0, 15));
      wdata1 = $urandom;
      #4;
      model_check(g);
      model_clock(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single-port image memory (16-bit word address, 32-bit data, 1-cycle synchronous read) between the edge-detection accelerator (requester 0) and a host/loader port (requester 1).
- Sits between both requesters and the memory's en/we/addr/dataW/dataR pins.
- Arbitration is round-robin with bounded bursts, so a host can read out results or preload a frame while the accelerator runs.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, memory data width (4 packed 8-bit pixels)
MAX_BURST, 16, max consecutive beats one requester holds the memory while the other waits; 0 = unlimited

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 (accelerator) access request
we0  in  1  requester 0 write enable (0 = read)
addr0  in  ADDR_W  requester 0 word address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 access accepted this cycle
rdata0  out  DATA_W  requester 0 read data
rvalid0  out  1  rdata0 valid (one cycle after granted read)
req1/we1/addr1/wdata1/gnt1/rdata1/rvalid1  same as above for requester 1 (host)
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en & ~mem_we
busy  out  1  high while state != IDLE

Behaviour:
- Beat: cycle in which reqN && gntN. Memory op issued that same cycle: mem_en=1, mem_we/addr/wdata = muxed from requester N (combinational path).
- No beat: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- gnt0/gnt1 are combinational from current req and registered state. At most one gnt high per cycle. gntN never high without reqN.
- State register: IDLE, OWN0, OWN1. Also a last-served pointer `last` (1 bit) and burst counter `bcnt` (width clog2(MAX_BURST+1), min 1).
- Decision per cycle:
  - IDLE: if only one requester asserts req, grant it. If both, grant ~last. Next state OWNwinner, bcnt=1, last=winner.
  - OWNn, reqn=1, other idle: grant n. bcnt saturating increment.
  - OWNn, reqn=1, other req=1, bcnt<MAX_BURST (or MAX_BURST=0): grant n, bcnt++.
  - OWNn, reqn=1, other req=1, bcnt==MAX_BURST: grant other the same cycle. Next state OWNother, bcnt=1, last=other.
  - OWNn, reqn=0, other req=1: grant other that cycle, switch as above. No idle bubble.
  - OWNn, both req=0: next state IDLE, bcnt=0.
- Read return: rvalidN registered: rvalidN <= beat_N && ~weN. rdataN = mem_rdata; both rdata outputs may be driven unconditionally, and only rvalid qualifies them.
- Back-to-back reads return one per cycle, in order. A switch between owners does not drop or reorder the in-flight return; the return goes to the requester that issued it.
- Requesters hold req/we/addr/wdata stable until gnt. Changes while ungranted are legal and take effect at grant.
- Reset (any cycle, incl. mid-burst or with a read in flight): state=IDLE, last=1 (so requester 0 wins the first tie), bcnt=0, rvalid0=rvalid1=0, busy=0.
  - While reset=1, gnt0=gnt1=0 and mem_en=0 regardless of req.
  - A read issued the cycle before reset produces no rvalid.
- busy = (state != IDLE), registered.

Test Plan:
1. Reset 3 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_en=0, rvalid0=rvalid1=0 throughout; first cycle after release gnt0=1 (last=1 at reset).
2. Requester 0 alone: write 0xDEADBEEF to addr 0x0010, then read 0x0010 -> gnt0 both cycles, mem_we=1 then 0, rvalid0 high one cycle after read with rdata0=0xDEADBEEF, rvalid1 stays 0.
3. Both requesting continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... with no idle cycle at any switch, and each mem_addr matching the owner's addr.
4. req0 held, req1 pulses 1 cycle at cycle 2 -> req1 waits for gnt. Holding it: after 4 beats of requester 0, gnt1=1 exactly once, then ownership returns to 0 when req1 drops.
5. Interleaved reads: owner 0 reads 0x6300 at the last beat before switching, owner 1 reads 0x0000 next cycle -> rvalid0 with mem[0x6300] first, rvalid1 with mem[0x0000] the following cycle, never both high together.
6. Assert reset the cycle after a granted read from requester 1 -> no rvalid1 pulse, state IDLE, busy=0 next cycle.
